wb_regfile: RTL and testbench
=============================

// Module: wb_regfile
// PURPOSE
//   Writeback stage plus integer register file for the RV32I pipeline; consumes the MEM/WB latch outputs.
//   Selects the writeback result, formats load data, and commits it to x1..x31.
//   Serves the decode stage's two combinational read ports.
//   Keeps a 64-bit retired-instruction counter for perf/debug.
// PARAMETERS
//   XLEN      32  datapath width; only 32 is supported
//   NREGS     32  architectural registers; x0 is hardwired zero
//   CNT_W     64  retired-instruction counter width
// PORTS
//   clk          in   1      pipeline clock, posedge
//   reset        in   1      asynchronous, active-low reset
//   ValidW       in   1      instruction in WB is real, not a bubble
//   RegWriteW    in   1      write enable from MEM/WB
//   WriteBackW   in   3      result select from MEM/WB
//   Funct3W      in   3      load width/sign code
//   ALUResultW   in   32     ALU result / load effective address
//   ReadDataW    in   32     raw data-memory word
//   PCPlus4W     in   32     link value for JAL/JALR
//   ImmExtW      in   32     U-immediate for LUI
//   RdW          in   5      destination register
//   Rs1D, Rs2D   in   5      decode-stage source indices
//   RD1D, RD2D   out  32     source operands to ID/EX
//   ResultW      out  32     selected writeback value, also feeds the forwarding muxes
//   InstRetW     out  64     retired-instruction count
// BEHAVIOUR
//   Reset (reset=0, async): all 31 registers = 0, InstRetW = 0. Comb outputs follow the cleared state.
//   Result select (WriteBackW):
//     000 ALUResultW; 001 formatted load; 010 PCPlus4W; 011 ImmExtW; 1xx ALUResultW.
//   Load format (Funct3W, byte lane = ALUResultW[1:0]):
//     000 LB: sign-extend selected byte.
//     001 LH: sign-extend half at ALUResultW[1].
//     010 LW: raw word.
//     100 LBU / 101 LHU: zero-extend the byte/half.
//     Other codes: raw word.
//   Write: at posedge, when RegWriteW & ValidW & RdW!=0, reg[RdW] <= ResultW. Writes to x0 are dropped.
//   Read: combinational. Index 0 always returns 32'h0.
//   Retire: InstRetW += 1 at every posedge with ValidW=1. Wraps 2^64-1 -> 0 silently.
//   Reset asserted mid-operation: the in-flight write is lost; registers and InstRetW clear immediately.
//   Latency: result commits 1 cycle after WB. The read sees it per CONFIGURATION.
// CONFIGURATION
//   WB_REGFILE_BYPASS_EN defined:
//     Write-through bypass. When RegWriteW & ValidW & RdW!=0 & RdW==Rs1D, RD1D = ResultW in the same cycle.
//     Same rule for RD2D with Rs2D.
//   Undefined:
//     Reads return stored state only. The hazard unit must add one stall for a WB->ID dependency.
// STRUCTURE
//   Package rv32_wb_pkg:
//     WB select codes WB_ALU/WB_LOAD/WB_PC4/WB_IMM.
//     funct3 load codes F3_LB/LH/LW/LBU/LHU.
//     XLEN, REG_AW localparams.
//   Sub-module load_formatter: pure combinational. (ReadDataW, addr[1:0], funct3) -> 32-bit load value.
//   Top: result mux, register array, write logic, read ports with optional bypass, retire counter.
// TESTING
//   1. Reset low with registers preloaded
//      -> all reads 0 and InstRetW=0, asynchronously, before the next clk edge.
//   2. WriteBackW=000, ALUResultW=32'h1234_5678, RdW=5, RegWriteW=ValidW=1; next cycle Rs1D=5
//      -> RD1D=32'h1234_5678, InstRetW=1.
//   3. Load formatting, WriteBackW=001, ReadDataW=32'h80FF_7F01:
//      - LB, addr[1:0]=3 -> ResultW=32'hFFFF_FF80
//      - LBU, addr[1:0]=2 -> 32'h0000_00FF
//      - LH, addr[1]=0 -> 32'h0000_7F01
//   4. RdW=0, ResultW=32'hDEAD_BEEF, RegWriteW=1 -> Rs1D=0 reads 0; InstRetW still increments.
//   5. Same-cycle write x7=32'hA5A5_A5A5 with Rs2D=7
//      -> RD2D=32'hA5A5_A5A5 with WB_REGFILE_BYPASS_EN; old value without it.
//   6. ValidW=0, RegWriteW=1, RdW=3 -> x3 unchanged, InstRetW unchanged.
//      Also: counter preset to 2^64-1 plus one ValidW cycle -> InstRetW=0.

Source files
------------

// File: rtl/rv32_wb_pkg.sv
// Shared writeback encodings for the RV32I pipeline: result-select and load funct3 codes.
package rv32_wb_pkg;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    typedef enum logic [2:0] {
        WB_ALU  = 3'b000,
        WB_LOAD = 3'b001,
        WB_PC4  = 3'b010,
        WB_IMM  = 3'b011
    } wbSel_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/wb_regfile_load_formatter.sv
// Combinational load-data aligner: picks the byte/half lane and sign- or zero-extends it.
module load_formatter
    import rv32_wb_pkg::*;
(
    input  logic [XLEN-1:0] readData,
    input  logic [1:0]      addr,
    input  logic [2:0]      funct3,
    output logic [XLEN-1:0] loadData
);

    logic [7:0]  byteV;
    logic [15:0] halfV;

    always_comb begin
        case (addr)
            2'd0:    byteV = readData[7:0];
            2'd1:    byteV = readData[15:8];
            2'd2:    byteV = readData[23:16];
            default: byteV = readData[31:24];
        endcase
        halfV = addr[1] ? readData[31:16] : readData[15:0];
    end

    always_comb begin
        case (funct3)
            F3_LB:   loadData = {{24{byteV[7]}}, byteV};
            F3_LH:   loadData = {{16{halfV[15]}}, halfV};
            F3_LW:   loadData = readData;
            F3_LBU:  loadData = {24'h0, byteV};
            F3_LHU:  loadData = {16'h0, halfV};
            default: loadData = readData;
        endcase
    end

endmodule

// File: rtl/wb_regfile.sv
// Writeback stage and integer register file with retired-instruction counter.
// Define WB_REGFILE_BYPASS_EN for same-cycle write-through on the read ports.
module wb_regfile #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int CNT_W = 64
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          ValidW,
    input  logic                          RegWriteW,
    input  logic [2:0]                    WriteBackW,
    input  logic [2:0]                    Funct3W,
    input  logic [XLEN-1:0]               ALUResultW,
    input  logic [XLEN-1:0]               ReadDataW,
    input  logic [XLEN-1:0]               PCPlus4W,
    input  logic [XLEN-1:0]               ImmExtW,
    input  logic [rv32_wb_pkg::REG_AW-1:0] RdW,
    input  logic [rv32_wb_pkg::REG_AW-1:0] Rs1D,
    input  logic [rv32_wb_pkg::REG_AW-1:0] Rs2D,
    output logic [XLEN-1:0]               RD1D,
    output logic [XLEN-1:0]               RD2D,
    output logic [XLEN-1:0]               ResultW,
    output logic [CNT_W-1:0]              InstRetW
);
    import rv32_wb_pkg::*;

    logic [XLEN-1:0]  regs [NREGS];
    logic [XLEN-1:0]  loadW;
    logic [CNT_W-1:0] instRet;
    logic             wrEn;

    load_formatter uFmt (
        .readData (ReadDataW),
        .addr     (ALUResultW[1:0]),
        .funct3   (Funct3W),
        .loadData (loadW)
    );

    always_comb begin
        case (WriteBackW)
            WB_ALU:  ResultW = ALUResultW;
            WB_LOAD: ResultW = loadW;
            WB_PC4:  ResultW = PCPlus4W;
            WB_IMM:  ResultW = ImmExtW;
            default: ResultW = ALUResultW;
        endcase
    end

    assign wrEn = RegWriteW && ValidW && (RdW != '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
            instRet <= '0;
        end else begin
            if (wrEn) regs[RdW] <= ResultW;
            if (ValidW) instRet <= instRet + CNT_W'(1);
        end
    end

    // x0 reads as zero regardless of array contents
    always_comb begin
        RD1D = (Rs1D == '0) ? '0 : regs[Rs1D];
        RD2D = (Rs2D == '0) ? '0 : regs[Rs2D];
`ifdef WB_REGFILE_BYPASS_EN
        if (wrEn && (Rs1D == RdW)) RD1D = ResultW;
        if (wrEn && (Rs2D == RdW)) RD2D = ResultW;
`endif
    end

    assign InstRetW = instRet;

endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile with a per-cycle reference model of the register file.
module tb_wb_regfile;

    logic        clk = 1'b0;
    logic        reset;
    logic        validW, regWriteW;
    logic [2:0]  writeBackW, funct3W;
    logic [31:0] aluResultW, readDataW, pcPlus4W, immExtW;
    logic [4:0]  rdW, rs1D, rs2D;
    logic [31:0] rd1D, rd2D, resultW;
    logic [63:0] instRetW;
    logic [31:0] rd1S, rd2S, resultS;
    logic [3:0]  instRetS;

    int checks = 0;
    int errors = 0;

    logic [31:0] model [32];
    longint unsigned modelCnt;

    always #5 clk = ~clk;

    wb_regfile dut (
        .clk(clk), .reset(reset), .ValidW(validW), .RegWriteW(regWriteW),
        .WriteBackW(writeBackW), .Funct3W(funct3W), .ALUResultW(aluResultW),
        .ReadDataW(readDataW), .PCPlus4W(pcPlus4W), .ImmExtW(immExtW),
        .RdW(rdW), .Rs1D(rs1D), .Rs2D(rs2D),
        .RD1D(rd1D), .RD2D(rd2D), .ResultW(resultW), .InstRetW(instRetW)
    );

    wb_regfile #(.CNT_W(4)) dutSmall (
        .clk(clk), .reset(reset), .ValidW(validW), .RegWriteW(regWriteW),
        .WriteBackW(writeBackW), .Funct3W(funct3W), .ALUResultW(aluResultW),
        .ReadDataW(readDataW), .PCPlus4W(pcPlus4W), .ImmExtW(immExtW),
        .RdW(rdW), .Rs1D(rs1D), .Rs2D(rs2D),
        .RD1D(rd1S), .RD2D(rd2S), .ResultW(resultS), .InstRetW(instRetS)
    );

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] expLoad();
        logic [31:0] b, h;
        b = (readDataW >> (8 * aluResultW[1:0])) & 32'hFF;
        h = (readDataW >> (16 * aluResultW[1])) & 32'hFFFF;
        case (funct3W)
            3'd0:    return (b >= 32'h80) ? (b | 32'hFFFF_FF00) : b;
            3'd1:    return (h >= 32'h8000) ? (h | 32'hFFFF_0000) : h;
            3'd4:    return b;
            3'd5:    return h;
            default: return readDataW;
        endcase
    endfunction

    function automatic logic [31:0] expResult();
        case (writeBackW)
            3'd1:    return expLoad();
            3'd2:    return pcPlus4W;
            3'd3:    return immExtW;
            default: return aluResultW;
        endcase
    endfunction

    function automatic bit writes();
        return validW && regWriteW && rdW != 0;
    endfunction

    function automatic logic [31:0] expRead(input logic [4:0] rs);
        if (rs == 0) return 32'h0;
`ifdef WB_REGFILE_BYPASS_EN
        if (writes() && rs == rdW) return expResult();
`endif
        return model[rs];
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) model[i] = 32'h0;
            modelCnt = 0;
        end else begin
            if (writes()) model[rdW] = expResult();
            if (validW) modelCnt = modelCnt + 1;
        end
    end

    always @(negedge clk) begin
        check("ResultW", resultW, expResult());
        check("RD1D", rd1D, expRead(rs1D));
        check("RD2D", rd2D, expRead(rs2D));
        check("InstRetW", instRetW, modelCnt);
        check("InstRetSmall", instRetS, modelCnt % 16);
    end

    task automatic setIn(input logic v, input logic rw, input logic [2:0] wb,
                         input logic [2:0] f3, input logic [31:0] alu,
                         input logic [31:0] rdata, input logic [31:0] imm,
                         input logic [4:0] rd, input logic [4:0] r1,
                         input logic [4:0] r2);
        validW = v; regWriteW = rw; writeBackW = wb; funct3W = f3;
        aluResultW = alu; readDataW = rdata; immExtW = imm;
        pcPlus4W = alu + 32'h4;
        rdW = rd; rs1D = r1; rs2D = r2;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0;
        setIn(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick(); tick();
        @(negedge clk);
        reset = 1'b1;
        tick();

        // ALU writeback then read
        setIn(1, 1, 3'd0, 0, 32'h1234_5678, 0, 0, 5'd5, 0, 0);
        #1 check("lit_alu_result", resultW, 32'h1234_5678);
        tick();
        setIn(0, 0, 3'd0, 0, 0, 0, 0, 0, 5'd5, 0);
        #1 check("lit_rd1_x5", rd1D, 32'h1234_5678);
        check("lit_instret1", instRetW, 64'd1);

        // load formatting
        setIn(1, 1, 3'd1, 3'd0, 32'h3, 32'h80FF_7F01, 0, 5'd10, 5'd10, 0);
        #1 check("lit_lb", resultW, 32'hFFFF_FF80);
        setIn(1, 1, 3'd1, 3'd4, 32'h2, 32'h80FF_7F01, 0, 5'd10, 5'd10, 0);
        #1 check("lit_lbu", resultW, 32'h0000_00FF);
        setIn(1, 1, 3'd1, 3'd1, 32'h0, 32'h80FF_7F01, 0, 5'd10, 5'd10, 0);
        #1 check("lit_lh", resultW, 32'h0000_7F01);
        tick();
        setIn(1, 1, 3'd1, 3'd5, 32'h2, 32'h80FF_7F01, 0, 5'd11, 5'd10, 0);
        #1 check("lit_lhu", resultW, 32'h0000_80FF);
        tick();

        // x0 write dropped, counter still advances
        setIn(1, 1, 3'd0, 0, 32'hDEAD_BEEF, 0, 0, 5'd0, 5'd0, 0);
        tick();
        #1 check("lit_x0", rd1D, 32'h0);
        check("lit_instret4", instRetW, 64'd4);

        // same-cycle write/read of x7
        setIn(1, 1, 3'd0, 0, 32'h1111_1111, 0, 0, 5'd7, 0, 0);
        tick();
        setIn(1, 1, 3'd3, 0, 32'h0, 0, 32'hA5A5_A5A5, 5'd7, 0, 5'd7);
`ifdef WB_REGFILE_BYPASS_EN
        #1 check("lit_bypass", rd2D, 32'hA5A5_A5A5);
`else
        #1 check("lit_nobypass", rd2D, 32'h1111_1111);
`endif
        tick();
        setIn(0, 0, 3'd0, 0, 0, 0, 0, 0, 0, 5'd7);
        #1 check("lit_x7", rd2D, 32'hA5A5_A5A5);

        // bubble with RegWriteW set
        setIn(0, 1, 3'd0, 0, 32'hCAFE_F00D, 0, 0, 5'd3, 5'd3, 0);
        tick();
        #1 check("lit_bubble_x3", rd1D, 32'h0);
        check("lit_instret6", instRetW, 64'd6);

        // PC+4 path and a sweep of writes with readback
        for (int i = 1; i < 32; i++) begin
            setIn(1, 1, 3'd2, 0, 32'h0101_0101 * i, 0, 0, 5'(i), 5'(i - 1), 5'(i));
            tick();
        end
        check("lit_instret37", instRetW, 64'd37);
        check("lit_small_wrap", instRetS, 4'd5);

        // small counter wrap 15 -> 0
        for (int i = 0; i < 10; i++) begin
            setIn(1, 0, 3'd0, 0, 0, 0, 0, 0, 5'd31, 5'd9);
            tick();
        end
        check("lit_small_15", instRetS, 4'd15);
        tick();
        check("lit_small_0", instRetS, 4'd0);
        check("lit_x9", rd2D, 32'h0909_090D);

        // asynchronous reset mid-cycle with live write
        setIn(1, 1, 3'd0, 0, 32'h7777_7777, 0, 0, 5'd9, 5'd31, 5'd9);
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        check("lit_rst_rd1", rd1D, 32'h0);
        check("lit_rst_rd2", rd2D, 32'h0);
        check("lit_rst_cnt", instRetW, 64'd0);
        tick();
        @(negedge clk);
        reset = 1'b1;
        setIn(0, 0, 3'd0, 0, 0, 0, 0, 0, 5'd31, 5'd9);
        tick();
        check("lit_post_rst", rd2D, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
